jstk_spi_slave: RTL and testbench

JSTK_SPI_SLAVE -- requirements
Module: jstk_spi_slave

---
 rtl/jstk_spi_slave.sv | 161 ++++++++++++++++
 tb/tb_jstk_spi_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_slave.sv
// SPI mode-0 slave for a joystick module: streams a 5-byte position/button
// report on MISO and takes an LED command from the first received byte.
module jstk_spi_slave #(
  parameter int unsigned MIN_CLK_RATIO = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCLK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] XPOS,
  input  logic [9:0] YPOS,
  input  logic [2:0] BTNS,
  output logic [1:0] LED,
  output logic       FRAME_DONE,
  output logic       FRAME_ABORT
);

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned RX_W       = 8;
  localparam logic [5:0]  LED_CMD    = 6'b100000;

  // Ratio is informational only; reject values the synchronizer cannot keep up with.
  if (MIN_CLK_RATIO < 2) begin : g_ratio_check
    $error("jstk_spi_slave: MIN_CLK_RATIO must be at least 2");
  end

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [RX_W-1:0]         rx_q, rx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              led_q, led_d;
  logic                    miso_q, miso_d;
  logic                    done_q, done_d;
  logic                    abort_q, abort_d;

  logic [2:0]              sclk_sync_q;
  logic [2:0]              ss_sync_q;
  logic [1:0]              mosi_sync_q;
  logic [1:0]              vld_q;
  logic                    armed_q, armed_d;

  logic                    sclk_rise_c, sclk_fall_c;
  logic                    ss_rise_c, ss_fall_c;
  logic                    mosi_c;
  logic [FRAME_BITS-1:0]   tx_load_c;

  // Synchronizers; the reset values model an idle bus (SS high, SCLK low).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      vld_q       <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      ss_sync_q   <= {ss_sync_q[1:0], SS};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      vld_q       <= {vld_q[0], 1'b1};
      armed_q     <= armed_d;
    end
  end

  assign sclk_rise_c = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_c = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_rise_c   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall_c   = ~ss_sync_q[1] & ss_sync_q[2];
  assign mosi_c      = mosi_sync_q[1];

  // A frame may only start after SS has genuinely been seen high since reset,
  // so a master still holding SS low across a reset cannot start a half frame.
  assign armed_d = armed_q | (vld_q[1] & ss_sync_q[1]);

  assign tx_load_c = {XPOS[7:0], 6'b000000, XPOS[9:8],
                      YPOS[7:0], 6'b000000, YPOS[9:8],
                      5'b00000, BTNS};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      led_q   <= 2'b00;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    done_d  = 1'b0;
    abort_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall_c && armed_q) begin
          state_d = ST_ACTIVE;
          tx_d    = tx_load_c;
          rx_d    = '0;
          cnt_d   = '0;
        end
      end

      ST_ACTIVE: begin
        // SS release wins over any SCLK edge seen in the same cycle.
        if (ss_rise_c) begin
          state_d = ST_IDLE;
          if (cnt_q == CNT_W'(FRAME_BITS)) begin
            done_d = 1'b1;
          end else begin
            abort_d = 1'b1;
          end
        end else begin
          if (sclk_rise_c && (cnt_q < CNT_W'(FRAME_BITS))) begin
            rx_d  = {rx_q[RX_W-2:0], mosi_c};
            cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q == CNT_W'(RX_W - 1)) && (rx_d[7:2] == LED_CMD)) begin
              led_d = rx_d[1:0];
            end
          end
          if (sclk_fall_c) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    miso_d = ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE)) ? tx_q[FRAME_BITS-1] : 1'b0;
  end

  assign MISO        = miso_q;
  assign LED         = led_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_ABORT = abort_q;

endmodule

// File: tb/tb_jstk_spi_slave.sv
// Directed bench for jstk_spi_slave: table of SPI frames plus hand-written
// sequences for mid-frame input changes and reset during a frame.
module tb_jstk_spi_slave;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SCLK;
  logic       SS;
  logic       MOSI;
  logic       MISO;
  logic [9:0] XPOS;
  logic [9:0] YPOS;
  logic [2:0] BTNS;
  logic [1:0] LED;
  logic       FRAME_DONE;
  logic       FRAME_ABORT;

  int total = 0;
  int bad   = 0;
  int done_cyc  = 0;
  int abort_cyc = 0;
  int both_cyc  = 0;

  jstk_spi_slave #(.MIN_CLK_RATIO(8)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .XPOS(XPOS), .YPOS(YPOS), .BTNS(BTNS), .LED(LED),
    .FRAME_DONE(FRAME_DONE), .FRAME_ABORT(FRAME_ABORT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) done_cyc++;
    if (FRAME_ABORT === 1'b1) abort_cyc++;
    if (FRAME_DONE === 1'b1 && FRAME_ABORT === 1'b1) both_cyc++;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  b;
    logic [47:0] mosi;
    int          n;
    logic [47:0] miso;
    logic [1:0]  led;
    int          done;
    int          abort;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic ss_low();
    SS = 1'b0;
    #100;
  endtask

  task automatic ss_high();
    #60;
    SS = 1'b1;
    #100;
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled just before the rising edge.
  task automatic run_bits(input int n, input logic [47:0] mosi, output logic [47:0] miso);
    miso = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = mosi[47-i];
      #60;
      miso[47-i] = MISO;
      SCLK = 1'b1;
      #60;
      SCLK = 1'b0;
    end
    MOSI = 1'b0;
  endtask

  task automatic full_frame(input logic [47:0] mosi, input int n, output logic [47:0] miso);
    done_cyc  = 0;
    abort_cyc = 0;
    ss_low();
    run_bits(n, mosi, miso);
    ss_high();
  endtask

  logic [47:0] got;

  initial begin
    vecs[0] = '{10'h2A5, 10'h13C, 3'b101, {8'h81, 40'h0}, 40, 48'hA5023C010500, 2'b01, 1, 0};
    vecs[1] = '{10'h2A5, 10'h13C, 3'b101, {8'h40, 40'h0}, 40, 48'hA5023C010500, 2'b01, 1, 0};
    vecs[2] = '{10'h2A5, 10'h13C, 3'b101, {8'h00, 40'h0}, 12, 48'hA50000000000, 2'b01, 0, 1};
    vecs[3] = '{10'h2A5, 10'h13C, 3'b101, {8'h83, 40'h0}, 48, 48'hA5023C010500, 2'b11, 1, 0};
    vecs[4] = '{10'h3FF, 10'h000, 3'b010, {8'h80, 40'h0}, 40, 48'hFF0300000200, 2'b00, 1, 0};
    vecs[5] = '{10'h155, 10'h2AA, 3'b111, {8'h84, 40'h0}, 40, 48'h5501AA020700, 2'b00, 1, 0};

    RST  = 1'b1;
    SCLK = 1'b0;
    SS   = 1'b1;
    MOSI = 1'b0;
    XPOS = '0;
    YPOS = '0;
    BTNS = '0;
    #30;
    check("reset_miso",  48'(MISO), 48'h0);
    check("reset_led",   48'(LED), 48'h0);
    check("reset_done",  48'(FRAME_DONE), 48'h0);
    check("reset_abort", 48'(FRAME_ABORT), 48'h0);
    RST = 1'b0;
    #100;

    for (int v = 0; v < 6; v++) begin
      XPOS = vecs[v].x;
      YPOS = vecs[v].y;
      BTNS = vecs[v].b;
      full_frame(vecs[v].mosi, vecs[v].n, got);
      check($sformatf("vec%0d_miso", v), got, vecs[v].miso);
      check($sformatf("vec%0d_led", v), 48'(LED), 48'(vecs[v].led));
      check($sformatf("vec%0d_done", v), 48'(done_cyc), 48'(vecs[v].done));
      check($sformatf("vec%0d_abort", v), 48'(abort_cyc), 48'(vecs[v].abort));
      check($sformatf("vec%0d_idle_miso", v), 48'(MISO), 48'h0);
    end

    // Position change after SS fall must not leak into the current frame.
    XPOS = 10'h000;
    YPOS = 10'h000;
    BTNS = 3'b000;
    done_cyc  = 0;
    abort_cyc = 0;
    ss_low();
    XPOS = 10'h3FF;
    run_bits(40, 48'h0, got);
    ss_high();
    check("hold_old_miso", got, 48'h000000000000);
    check("hold_old_done", 48'(done_cyc), 48'd1);
    full_frame(48'h0, 40, got);
    check("hold_new_miso", got, 48'hFF0300000000);
    check("hold_new_done", 48'(done_cyc), 48'd1);
    check("hold_new_led", 48'(LED), 48'h0);

    // Reset at bit 20 with SS still low: no pulses, dead until a fresh SS fall.
    XPOS = 10'h2A5;
    YPOS = 10'h13C;
    BTNS = 3'b101;
    done_cyc  = 0;
    abort_cyc = 0;
    ss_low();
    run_bits(20, {8'h83, 40'h0}, got);
    check("rst_pre_led", 48'(LED), 48'h3);
    RST = 1'b1;
    #30;
    RST = 1'b0;
    #100;
    check("rst_led_clear", 48'(LED), 48'h0);
    run_bits(8, {8'h83, 40'h0}, got);
    check("rst_dead_miso", got, 48'h0);
    check("rst_dead_led", 48'(LED), 48'h0);
    ss_high();
    check("rst_no_done", 48'(done_cyc), 48'd0);
    check("rst_no_abort", 48'(abort_cyc), 48'd0);
    full_frame({8'h81, 40'h0}, 40, got);
    check("rst_next_miso", got, 48'hA5023C010500);
    check("rst_next_led", 48'(LED), 48'h1);
    check("rst_next_done", 48'(done_cyc), 48'd1);
    check("rst_next_abort", 48'(abort_cyc), 48'd0);

    check("never_both", 48'(both_cyc), 48'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
